// File: rtl/spike_encoder_if.sv
// Pixel handshake between an upstream image source (master) and the spike encoder (slave).
interface spike_encoder_if #(
  parameter int INT_WIDTH = 8
);
  logic                 pix_valid;
  logic                 pix_ready;
  logic [INT_WIDTH-1:0] pix_data;
  logic [INT_WIDTH-1:0] threshold;

  modport master (output pix_valid, output pix_data, output threshold, input pix_ready);
  modport slave  (input pix_valid, input pix_data, input threshold, output pix_ready);
endinterface

// File: rtl/spike_encoder.sv
// Time-to-first-spike encoder: fills a shadow frame of pixel spike times and publishes it
// as a whole frame at the start of each time period once the shadow buffer is complete.
module spike_encoder #(
  parameter int NUM_SPIKES      = 16,
  parameter int INT_WIDTH       = 8,
  parameter int LOG_TIME_PERIOD = 3
) (
  input  logic                                       clk,
  input  logic                                       rst_l,
  spike_encoder_if.slave                             pix,
  output logic [LOG_TIME_PERIOD:0]                   time_val,
  output logic [NUM_SPIKES*(LOG_TIME_PERIOD+1)-1:0]  spike_times,
  output logic                                       frame_valid,
  output logic                                       frame_start
);
  localparam int TW          = LOG_TIME_PERIOD + 1;
  localparam int TIME_PERIOD = 1 << LOG_TIME_PERIOD;
  localparam int IDX_W       = (NUM_SPIKES > 1) ? $clog2(NUM_SPIKES) : 1;
  localparam logic [TW-1:0]    NO_SPIKE   = TW'(TIME_PERIOD);
  localparam logic [TW-1:0]    LAST_PHASE = TW'(TIME_PERIOD - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_SPIKES - 1);

  typedef enum logic {FILL, FULL} state_e;

  state_e                        state_q, state_d;
  logic [IDX_W-1:0]              index_q, index_d;
  logic [NUM_SPIKES-1:0][TW-1:0] shadow_q, shadow_d;
  logic [NUM_SPIKES-1:0][TW-1:0] spikes_q, spikes_d;
  logic [TW-1:0]                 time_q, time_d;
  logic                          frame_valid_q, frame_valid_d;
  logic                          frame_start_q, frame_start_d;
  logic                          ready_q, ready_d;
  logic                          wrap;
  logic                          accept;
  logic [TW-1:0]                 slot_val;

  assign wrap   = (time_q == LAST_PHASE);
  assign accept = pix.pix_valid & ready_q;

  // Top bits of the inverted intensity equal (max - pix) >> (INT_WIDTH - LOG_TIME_PERIOD).
  always_comb begin
    slot_val = {1'b0, ~pix.pix_data[INT_WIDTH-1 -: LOG_TIME_PERIOD]};
    if (pix.pix_data < pix.threshold) begin
      slot_val = NO_SPIKE;
    end
  end

  always_comb begin
    state_d       = state_q;
    index_d       = index_q;
    shadow_d      = shadow_q;
    spikes_d      = spikes_q;
    frame_valid_d = frame_valid_q;
    frame_start_d = 1'b0;
    time_d        = wrap ? '0 : time_q + 1'b1;

    if (state_q == FILL && accept) begin
      shadow_d[index_q] = slot_val;
      if (index_q == LAST_IDX) begin
        state_d = FULL;
      end else begin
        index_d = index_q + 1'b1;
      end
    end

    // Output frame registers only ever move at the period boundary.
    if (wrap) begin
      if (state_q == FULL) begin
        spikes_d      = shadow_q;
        frame_valid_d = 1'b1;
        frame_start_d = 1'b1;
        state_d       = FILL;
        index_d       = '0;
      end else begin
        spikes_d      = {NUM_SPIKES{NO_SPIKE}};
        frame_valid_d = 1'b0;
      end
    end

    ready_d = (state_d == FILL);
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q       <= FILL;
      index_q       <= '0;
      shadow_q      <= {NUM_SPIKES{NO_SPIKE}};
      spikes_q      <= {NUM_SPIKES{NO_SPIKE}};
      time_q        <= '0;
      frame_valid_q <= 1'b0;
      frame_start_q <= 1'b0;
      ready_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      index_q       <= index_d;
      shadow_q      <= shadow_d;
      spikes_q      <= spikes_d;
      time_q        <= time_d;
      frame_valid_q <= frame_valid_d;
      frame_start_q <= frame_start_d;
      ready_q       <= ready_d;
    end
  end

  assign pix.pix_ready = ready_q;
  assign time_val      = time_q;
  assign spike_times   = spikes_q;
  assign frame_valid   = frame_valid_q;
  assign frame_start   = frame_start_q;
endmodule

// File: tb/tb_spike_encoder.sv
// Directed testbench for spike_encoder: reset, full frame, conversion, backpressure,
// wrap-edge boundary and reset mid-fill scenarios.
module tb_spike_encoder;
  localparam int N  = 16;
  localparam int W  = 8;
  localparam int L  = 3;
  localparam int TP = 8;
  localparam int TW = L + 1;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  always #5 clk = ~clk;

  spike_encoder_if #(.INT_WIDTH(W)) pix ();
  logic [TW-1:0]   time_val;
  logic [N*TW-1:0] spike_times;
  logic            frame_valid;
  logic            frame_start;

  spike_encoder #(.NUM_SPIKES(N), .INT_WIDTH(W), .LOG_TIME_PERIOD(L)) dut (
    .clk         (clk),
    .rst_l       (rst_l),
    .pix         (pix),
    .time_val    (time_val),
    .spike_times (spike_times),
    .frame_valid (frame_valid),
    .frame_start (frame_start)
  );

  int errors = 0;
  int checks = 0;
  int phase  = 0;

  logic [N*TW-1:0] all8;
  logic [N*TW-1:0] all0;
  logic [N*TW-1:0] all1;
  logic [N*TW-1:0] exp_vec;
  logic [W-1:0]    px [N];
  logic [W-1:0]    th [N];
  logic [TW-1:0]   ex [N];

  task automatic tick();
    @(posedge clk);
    #1;
    phase = (phase + 1) % TP;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (time_val !== '0) begin errors++; $display("FAIL rst_time: got %0d want 0", time_val); end
    checks++; if (spike_times !== all8) begin errors++; $display("FAIL rst_spikes: got %h want %h", spike_times, all8); end
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL rst_fv: got %b want 0", frame_valid); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL rst_fs: got %b want 0", frame_start); end
    checks++; if (pix.pix_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", pix.pix_ready); end
    @(negedge clk);
    rst_l = 1'b1;
    @(posedge clk);
    #1;
    phase = 1;
    checks++; if (pix.pix_ready !== 1'b1) begin errors++; $display("FAIL rel_ready: got %b want 1", pix.pix_ready); end
    checks++; if (time_val !== 4'd1) begin errors++; $display("FAIL rel_time: got %0d want 1", time_val); end
    $display("test_reset done");
  endtask

  task automatic test_full_frame();
    pix.pix_valid = 1'b1;
    pix.pix_data  = 8'd255;
    pix.threshold = 8'd0;
    for (int i = 0; i < N; i++) begin
      checks++; if (pix.pix_ready !== 1'b1) begin errors++; $display("FAIL ff_ready[%0d]: got %b want 1", i, pix.pix_ready); end
      tick();
    end
    pix.pix_valid = 1'b0;
    checks++; if (pix.pix_ready !== 1'b0) begin errors++; $display("FAIL ff_ready_drop: got %b want 0", pix.pix_ready); end
    while (phase != 0) begin
      checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL ff_early_fv: got %b want 0", frame_valid); end
      tick();
    end
    checks++; if (time_val !== '0) begin errors++; $display("FAIL ff_time0: got %0d want 0", time_val); end
    checks++; if (spike_times !== all0) begin errors++; $display("FAIL ff_spikes: got %h want %h", spike_times, all0); end
    checks++; if (frame_valid !== 1'b1 || frame_start !== 1'b1) begin errors++; $display("FAIL ff_first: fv=%b fs=%b want 1 1", frame_valid, frame_start); end
    for (int c = 1; c < TP; c++) begin
      tick();
      checks++; if (frame_valid !== 1'b1 || frame_start !== 1'b0 || spike_times !== all0) begin
        errors++; $display("FAIL ff_hold[%0d]: fv=%b fs=%b spikes=%h want 1 0 %h", c, frame_valid, frame_start, spike_times, all0);
      end
    end
    tick();
    checks++; if (frame_valid !== 1'b0 || frame_start !== 1'b0 || spike_times !== all8) begin
      errors++; $display("FAIL ff_after: fv=%b fs=%b spikes=%h want 0 0 %h", frame_valid, frame_start, spike_times, all8);
    end
    $display("test_full_frame done");
  endtask

  task automatic test_conversion_backpressure();
    px = '{8'd0, 8'd31, 8'd32, 8'd128, 8'd255, 8'd31, 8'd32, 8'd100,
           8'd99, 8'd64, 8'd63, 8'd1, 8'd254, 8'd127, 8'd224, 8'd223};
    th = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd100, 8'd100, 8'd100,
           8'd100, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    ex = '{4'd7, 4'd7, 4'd6, 4'd3, 4'd0, 4'd8, 4'd8, 4'd4,
           4'd8, 4'd5, 4'd6, 4'd7, 4'd0, 4'd4, 4'd0, 4'd1};
    for (int i = 0; i < N; i++) exp_vec[i*TW +: TW] = ex[i];
    repeat (3) tick();
    for (int i = 0; i < N; i++) begin
      pix.pix_valid = 1'b1;
      pix.pix_data  = px[i];
      pix.threshold = th[i];
      checks++; if (pix.pix_ready !== 1'b1) begin errors++; $display("FAIL cv_ready[%0d]: got %b want 1", i, pix.pix_ready); end
      tick();
    end
    do begin
      pix.pix_valid = 1'b1;
      pix.pix_data  = W'($urandom);
      pix.threshold = 8'd0;
      checks++; if (pix.pix_ready !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b want 0", pix.pix_ready); end
      tick();
    end while (phase != 0);
    pix.pix_valid = 1'b0;
    checks++; if (spike_times !== exp_vec) begin errors++; $display("FAIL cv_spikes: got %h want %h", spike_times, exp_vec); end
    checks++; if (frame_valid !== 1'b1 || frame_start !== 1'b1) begin errors++; $display("FAIL cv_first: fv=%b fs=%b want 1 1", frame_valid, frame_start); end
    repeat (TP) tick();
    checks++; if (frame_valid !== 1'b0 || spike_times !== all8) begin errors++; $display("FAIL cv_after: fv=%b spikes=%h want 0 %h", frame_valid, spike_times, all8); end
    $display("test_conversion_backpressure done");
  endtask

  task automatic test_boundary();
    while (phase != 0) tick();
    for (int i = 0; i < N; i++) begin
      pix.pix_valid = 1'b1;
      pix.pix_data  = 8'd200;
      pix.threshold = 8'd0;
      checks++; if (pix.pix_ready !== 1'b1) begin errors++; $display("FAIL bd_ready[%0d]: got %b want 1", i, pix.pix_ready); end
      tick();
    end
    pix.pix_valid = 1'b0;
    checks++; if (pix.pix_ready !== 1'b0) begin errors++; $display("FAIL bd_full: got %b want 0", pix.pix_ready); end
    for (int c = 0; c < TP; c++) begin
      checks++; if (frame_valid !== 1'b0 || spike_times !== all8) begin
        errors++; $display("FAIL bd_gap[%0d]: fv=%b spikes=%h want 0 %h", c, frame_valid, spike_times, all8);
      end
      tick();
    end
    checks++; if (frame_valid !== 1'b1 || frame_start !== 1'b1 || spike_times !== all1) begin
      errors++; $display("FAIL bd_frame: fv=%b fs=%b spikes=%h want 1 1 %h", frame_valid, frame_start, spike_times, all1);
    end
    repeat (TP) tick();
    $display("test_boundary done");
  endtask

  task automatic test_reset_mid_fill();
    for (int i = 0; i < 10; i++) begin
      pix.pix_valid = 1'b1;
      pix.pix_data  = 8'd255;
      pix.threshold = 8'd0;
      tick();
    end
    pix.pix_valid = 1'b0;
    rst_l = 1'b0;
    #2;
    checks++; if (time_val !== '0 || frame_valid !== 1'b0 || frame_start !== 1'b0 || pix.pix_ready !== 1'b0 || spike_times !== all8) begin
      errors++; $display("FAIL mr_async: t=%0d fv=%b fs=%b rdy=%b spikes=%h want 0 0 0 0 %h", time_val, frame_valid, frame_start, pix.pix_ready, spike_times, all8);
    end
    @(negedge clk);
    rst_l = 1'b1;
    @(posedge clk);
    #1;
    phase = 1;
    checks++; if (pix.pix_ready !== 1'b1) begin errors++; $display("FAIL mr_ready: got %b want 1", pix.pix_ready); end
    for (int i = 0; i < 6; i++) begin
      pix.pix_valid = 1'b1;
      pix.pix_data  = 8'd0;
      pix.threshold = 8'd1;
      tick();
    end
    pix.pix_valid = 1'b0;
    for (int c = 0; c < 2*TP; c++) begin
      checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL mr_no_frame[%0d]: fv=%b want 0", c, frame_valid); end
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      pix.pix_valid = 1'b1;
      pix.pix_data  = 8'd0;
      pix.threshold = 8'd1;
      checks++; if (pix.pix_ready !== 1'b1) begin errors++; $display("FAIL mr_ready2[%0d]: got %b want 1", i, pix.pix_ready); end
      tick();
    end
    pix.pix_valid = 1'b0;
    do tick(); while (phase != 0);
    checks++; if (frame_valid !== 1'b1 || frame_start !== 1'b1 || spike_times !== all8) begin
      errors++; $display("FAIL mr_frame: fv=%b fs=%b spikes=%h want 1 1 %h", frame_valid, frame_start, spike_times, all8);
    end
    $display("test_reset_mid_fill done");
  endtask

  initial begin
    all8 = {N{4'd8}};
    all0 = '0;
    all1 = {N{4'd1}};
    pix.pix_valid = 1'b0;
    pix.pix_data  = '0;
    pix.threshold = '0;
    test_reset();
    test_full_frame();
    test_conversion_backpressure();
    test_boundary();
    test_reset_mid_fill();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
